// File: rtl/apb_master.sv
// apb_master: turns single-beat commands into APB SETUP/ACCESS transfers and reports the response.
module apb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       PSELx,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [6:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] PRDATA,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic done, abort, accept;
  assign done = state == ACCESS && PREADY;
  assign cmd_ready = state == IDLE || done;
  assign accept = cmd_valid && cmd_ready;
  assign busy = state != IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  assign abort = state == ACCESS && !PREADY && wait_cnt == 16'(TIMEOUT);
`else
  assign abort = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state <= IDLE;
      PSELx <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE <= 1'b0;
      PADDR <= 7'h00;
      PWDATA <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      wait_cnt <= 16'h0000;
`endif
    end else begin
      rsp_valid <= done || abort;
      if (done) begin
        rsp_rdata <= PWRITE ? 8'h00 : PRDATA;
        rsp_err <= PSLVERR;
      end else if (abort) begin
        rsp_rdata <= 8'h00;
        rsp_err <= 1'b1;
      end
`ifdef APB_MASTER_TIMEOUT_EN
      if (done || abort) rsp_timeout <= abort;
      if (state == SETUP) wait_cnt <= 16'h0000;
      else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 16'd1;
`endif
      if (accept) begin
        state <= SETUP;
        PSELx <= 1'b1;
        PENABLE <= 1'b0;
        PWRITE <= cmd_write;
        PADDR <= cmd_addr;
        PWDATA <= cmd_write ? cmd_wdata : 8'h00;
      end else if (state == SETUP) begin
        state <= ACCESS;
        PENABLE <= 1'b1;
      end else if (done || abort) begin
        state <= IDLE;
        PSELx <= 1'b0;
        PENABLE <= 1'b0;
      end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of apb_master transfers, wait states, errors, watchdog and reset.
module tb_apb_master;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       PSELx, PENABLE, PWRITE;
  logic [6:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY = 1'b0, PSLVERR = 1'b0;
  logic [7:0] PRDATA = 8'h00;
  logic       rsp_valid, rsp_err, rsp_timeout, busy;
  logic [7:0] rsp_rdata;
  int         vectors = 0, miscompares = 0;

  apb_master #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
  endtask

  initial begin
    int pulses;
    @(negedge PCLK);
    check("rst_psel", PSELx, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;
    @(negedge PCLK);
    PREADY = 1'b1;
    issue(1'b1, 7'h2A, 8'h5C);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("w_setup_psel", PSELx, 1);
    check("w_setup_penable", PENABLE, 0);
    check("w_paddr", PADDR, 7'h2A);
    check("w_pwdata", PWDATA, 8'h5C);
    check("w_pwrite", PWRITE, 1);
    check("w_setup_ready", cmd_ready, 0);
    check("w_busy", busy, 1);
    @(negedge PCLK);
    check("w_access_psel", PSELx, 1);
    check("w_access_penable", PENABLE, 1);
    check("w_access_ready", cmd_ready, 1);
    check("w_access_no_rsp", rsp_valid, 0);
    @(negedge PCLK);
    check("w_rsp_valid", rsp_valid, 1);
    check("w_rsp_rdata", rsp_rdata, 0);
    check("w_rsp_err", rsp_err, 0);
    check("w_idle_psel", PSELx, 0);
    check("w_idle_penable", PENABLE, 0);
    check("w_idle_paddr_hold", PADDR, 7'h2A);
    check("w_idle_busy", busy, 0);
    @(negedge PCLK);
    check("w_rsp_pulse", rsp_valid, 0);
    PREADY = 1'b0;
    PRDATA = 8'hFF;
    issue(1'b0, 7'h11, 8'h99);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("r_pwdata_zero", PWDATA, 0);
    check("r_pwrite", PWRITE, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("r_wait_penable", PENABLE, 1);
      check("r_wait_paddr", PADDR, 7'h11);
      check("r_wait_pwrite", PWRITE, 0);
      check("r_wait_ready", cmd_ready, 0);
      check("r_wait_no_rsp", rsp_valid, 0);
    end
    @(negedge PCLK);
    check("r_last_penable", PENABLE, 1);
    check("r_last_paddr", PADDR, 7'h11);
    PREADY = 1'b1;
    PRDATA = 8'hA7;
    #1;
    check("r_done_ready", cmd_ready, 1);
    @(negedge PCLK);
    check("r_rsp_valid", rsp_valid, 1);
    check("r_rsp_rdata", rsp_rdata, 8'hA7);
    check("r_rsp_err", rsp_err, 0);
    @(negedge PCLK);
    issue(1'b1, 7'h01, 8'h01);
    @(negedge PCLK);
    check("b2b_1_setup_paddr", PADDR, 7'h01);
    check("b2b_1_setup_penable", PENABLE, 0);
    issue(1'b0, 7'h02, 8'h00);
    @(negedge PCLK);
    check("b2b_1_access_penable", PENABLE, 1);
    check("b2b_1_access_paddr", PADDR, 7'h01);
    PRDATA = 8'h5A;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("b2b_rsp1_valid", rsp_valid, 1);
    check("b2b_rsp1_rdata", rsp_rdata, 0);
    check("b2b_2_setup_psel", PSELx, 1);
    check("b2b_2_setup_penable", PENABLE, 0);
    check("b2b_2_paddr", PADDR, 7'h02);
    check("b2b_2_pwrite", PWRITE, 0);
    @(negedge PCLK);
    check("b2b_2_access_psel", PSELx, 1);
    check("b2b_2_access_penable", PENABLE, 1);
    check("b2b_gap_no_rsp", rsp_valid, 0);
    @(negedge PCLK);
    check("b2b_rsp2_valid", rsp_valid, 1);
    check("b2b_rsp2_rdata", rsp_rdata, 8'h5A);
    check("b2b_2_idle_psel", PSELx, 0);
    @(negedge PCLK);
    PSLVERR = 1'b1;
    PRDATA = 8'h3C;
    issue(1'b0, 7'h33, 8'h00);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 8'h3C);
    PSLVERR = 1'b0;
    issue(1'b1, 7'h40, 8'h77);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("err_hold_err", rsp_err, 1);
    check("err_hold_rdata", rsp_rdata, 8'h3C);
    check("err_hold_no_rsp", rsp_valid, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    check("ok_rsp_valid", rsp_valid, 1);
    check("ok_rsp_err", rsp_err, 0);
    check("ok_rsp_rdata", rsp_rdata, 0);
    check("ok_rsp_timeout", rsp_timeout, 0);
    @(negedge PCLK);
    PREADY = 1'b0;
    issue(1'b0, 7'h05, 8'h00);
    @(negedge PCLK);
    cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      check("to_wait_psel", PSELx, 1);
      check("to_wait_no_rsp", rsp_valid, 0);
      check("to_wait_ready", cmd_ready, 0);
    end
    @(negedge PCLK);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_timeout", rsp_timeout, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", PSELx, 0);
    check("to_penable", PENABLE, 0);
    check("to_busy", busy, 0);
    @(negedge PCLK);
    issue(1'b0, 7'h06, 8'h00);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
`else
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge PCLK);
      pulses += int'(rsp_valid);
    end
    check("hang_no_rsp", 16'(pulses), 0);
    check("hang_psel", PSELx, 1);
    check("hang_penable", PENABLE, 1);
    check("hang_timeout_tied", rsp_timeout, 0);
`endif
    check("rst_mid_in_access", PENABLE, 1);
    PREADY = 1'b1;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_psel", PSELx, 0);
    check("rst_mid_penable", PENABLE, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", cmd_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      pulses += int'(rsp_valid);
    end
    check("rst_post_no_rsp", 16'(pulses), 0);
    check("rst_post_ready", cmd_ready, 1);
    check("rst_post_psel", PSELx, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
